// File: rtl/evm_vote_scheduler_pkg.sv
// Shared types and helpers for the voting machine ballot controller.
// Holds the FSM state encoding, the tally width/limit and a one-hot check
// used to qualify candidate button presses.
package evm_pkg;

  // Ballot controller phases
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCK    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Tallies match the 3-bit input of the shared segment decoder
  localparam int TALLY_W = 3;
  localparam logic [TALLY_W-1:0] TALLY_MAX = 3'd7;

  // Widest candidate vector the one-hot helper accepts
  localparam int MAX_CAND = 8;
  localparam logic [MAX_CAND-1:0] ONE_V = {{(MAX_CAND-1){1'b0}}, 1'b1};

  // True when exactly one bit of v is set
  function automatic logic is_one_hot(input logic [MAX_CAND-1:0] v);
    logic [MAX_CAND-1:0] lower;
    lower = v - ONE_V;
    return (v != '0) && ((v & lower) == '0);
  endfunction

endpackage

// File: rtl/evm_vote_scheduler_if.sv
// Bus between the officer panel / display and the ballot controller.
// The master side drives the panel inputs; the slave side is the controller.
interface evm_vote_scheduler_if #(
  parameter int NUM_CAND = 4
);
  import evm_pkg::*;

  logic                ballot_en;
  logic [NUM_CAND-1:0] cand_btn;
  logic                clear_all;
  logic [TALLY_W-1:0]  seg_count;
  logic [NUM_CAND-1:0] digit_en;
  logic                armed;
  logic                vote_ack;
  logic [NUM_CAND-1:0] overflow;

  modport master (
    output ballot_en, cand_btn, clear_all,
    input  seg_count, digit_en, armed, vote_ack, overflow
  );

  modport slave (
    input  ballot_en, cand_btn, clear_all,
    output seg_count, digit_en, armed, vote_ack, overflow
  );

endinterface

// File: rtl/evm_display_scan.sv
// Display scanner: holds each digit for SCAN_DIV cycles and walks the
// digit index round-robin over all candidates. Runs freely, independent of
// the ballot FSM, so the display keeps refreshing during every phase.
module evm_display_scan #(
  parameter int NUM_CAND = 4,
  parameter int SCAN_DIV = 16,
  localparam int IDX_W   = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [IDX_W-1:0]    scan_idx,
  output logic [NUM_CAND-1:0] digit_en
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CAND - 1);

  logic [PRE_W-1:0] presc;

  // Prescaler wraps at SCAN_DIV-1 and steps the digit index on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PRE_LAST) begin
      presc    <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // One-hot digit enable decoded straight from the registered index
  always_comb begin
    digit_en = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      digit_en[i] = (scan_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/evm_vote_scheduler.sv
// Ballot controller for the FPGA voting machine. An officer arms one vote,
// the voter presses exactly one candidate button, the matching 3-bit tally
// saturates at 7 (flagging overflow), and a lockout plus release wait stop a
// held button from voting twice. One external segment decoder is shared by
// all digits through the scan index driving seg_count and digit_en.
module evm_vote_scheduler
  import evm_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int SCAN_DIV    = 16,
  parameter int LOCK_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  evm_vote_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCK_CYCLES - 1);

  state_t              state;
  logic [LCK_W-1:0]    lock_cnt;
  logic [TALLY_W-1:0]  tally [NUM_CAND];
  logic [NUM_CAND-1:0] overflow_q;
  logic                vote_ack_q;
  logic                armed_q;
  logic                btn_valid;
  logic [IDX_W-1:0]    scan_idx;
  logic [NUM_CAND-1:0] digit_en;
  logic [TALLY_W-1:0]  seg_count;

  assign btn_valid = is_one_hot(MAX_CAND'(bus.cand_btn));

  // Free-running digit scanner shared by every tally
  evm_display_scan #(
    .NUM_CAND (NUM_CAND),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_idx (scan_idx),
    .digit_en (digit_en)
  );

  // Ballot FSM with tally storage, lockout counter and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lock_cnt   <= '0;
      overflow_q <= '0;
      vote_ack_q <= 1'b0;
      armed_q    <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) begin
        tally[i] <= '0;
      end
    end else begin
      vote_ack_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.clear_all) begin
            overflow_q <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
              tally[i] <= '0;
            end
          end else if (bus.ballot_en) begin
            state   <= ST_ARMED;
            armed_q <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (btn_valid) begin
            for (int i = 0; i < NUM_CAND; i++) begin
              if (bus.cand_btn[i]) begin
                if (tally[i] == TALLY_MAX) begin
                  overflow_q[i] <= 1'b1;
                end else begin
                  tally[i] <= tally[i] + TALLY_W'(1);
                end
              end
            end
            vote_ack_q <= 1'b1;
            armed_q    <= 1'b0;
            lock_cnt   <= LCK_LOAD;
            state      <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (lock_cnt == '0) begin
            state <= ST_RELEASE;
          end else begin
            lock_cnt <= lock_cnt - LCK_W'(1);
          end
        end
        ST_RELEASE: begin
          if (bus.cand_btn == '0) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  // Select the tally of the digit currently being scanned
  always_comb begin
    seg_count = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        seg_count = tally[i];
      end
    end
  end

  assign bus.seg_count = seg_count;
  assign bus.digit_en  = digit_en;
  assign bus.armed     = armed_q;
  assign bus.vote_ack  = vote_ack_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_evm_vote_scheduler.sv
// Self-checking bench for evm_vote_scheduler: a behavioural model tracks the
// ballot phases, tallies and scan position, and is compared every cycle;
// a vector table and hand sequences add fixed expectations for corner cases.
module tb_evm_vote_scheduler;
  import evm_pkg::*;

  localparam int NC = 4;
  localparam int SD = 16;
  localparam int LC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  evm_vote_scheduler_if #(.NUM_CAND(NC)) vif ();

  evm_vote_scheduler #(
    .NUM_CAND    (NC),
    .SCAN_DIV    (SD),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  int checks   = 0;
  int failures = 0;
  int ack_seen = 0;

  // Behavioural model state
  int          m_tally [NC];
  bit [NC-1:0] m_ovf;
  bit          m_open;
  int          m_lock_left;
  bit          m_wait_rel;
  bit          m_ack;
  int          m_cycles;

  typedef struct {
    bit          ballot;
    logic [NC-1:0] btn;
    bit          clr;
    bit          exp_armed;
    bit          exp_ack;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got=%0d want=%0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) m_tally[i] = 0;
    m_ovf       = '0;
    m_open      = 1'b0;
    m_lock_left = 0;
    m_wait_rel  = 1'b0;
    m_ack       = 1'b0;
    m_cycles    = 0;
  endfunction

  function automatic void model_step();
    m_cycles++;
    m_ack = 1'b0;
    if (m_open) begin
      if ($countones(vif.cand_btn) == 1) begin
        for (int k = 0; k < NC; k++) begin
          if (vif.cand_btn[k]) begin
            if (m_tally[k] == 7) m_ovf[k] = 1'b1;
            else m_tally[k] = m_tally[k] + 1;
          end
        end
        m_ack       = 1'b1;
        m_open      = 1'b0;
        m_lock_left = LC;
      end
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_wait_rel = 1'b1;
    end else if (m_wait_rel) begin
      if (vif.cand_btn == '0) m_wait_rel = 1'b0;
    end else begin
      if (vif.clear_all) begin
        for (int i = 0; i < NC; i++) m_tally[i] = 0;
        m_ovf = '0;
      end else if (vif.ballot_en) begin
        m_open = 1'b1;
      end
    end
  endfunction

  task automatic applyStimulus(input bit ballot, input logic [NC-1:0] btn, input bit clr);
    vif.ballot_en = ballot;
    vif.cand_btn  = btn;
    vif.clear_all = clr;
  endtask

  task automatic checkOutput();
    int idx;
    idx = (m_cycles / SD) % NC;
    check("armed", int'(vif.armed), int'(m_open));
    check("vote_ack", int'(vif.vote_ack), int'(m_ack));
    check("overflow", int'(vif.overflow), int'(m_ovf));
    check("digit_en", int'(vif.digit_en), 1 << idx);
    check("seg_count", int'(vif.seg_count), m_tally[idx]);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput();
    ack_seen += int'(vif.vote_ack);
  endtask

  task automatic showDigit(input int k, input int exp_val, input string name);
    int waited = 0;
    while (!vif.digit_en[k] && waited < NC * SD) begin
      stepCycle();
      waited++;
    end
    check({name, "_found"}, int'(vif.digit_en[k]), 1);
    check(name, int'(vif.seg_count), exp_val);
  endtask

  task automatic castVote(input int k);
    applyStimulus(1'b1, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, NC'(1) << k, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0);
    repeat (LC + 2) stepCycle();
  endtask

  initial begin
    vec_t tbl [5];
    logic [NC-1:0] rb;

    tbl[0] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};

    applyStimulus(1'b0, '0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_armed", int'(vif.armed), 0);
    check("rst_ack", int'(vif.vote_ack), 0);
    check("rst_overflow", int'(vif.overflow), 0);
    check("rst_digit_en", int'(vif.digit_en), 1);
    check("rst_seg_count", int'(vif.seg_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: each digit held SD cycles, wraps after NC digits
    repeat (SD) stepCycle();
    check("scan_digit1", int'(vif.digit_en), 4'b0010);
    repeat (3 * SD) stepCycle();
    check("scan_wrap", int'(vif.digit_en), 4'b0001);

    // Multi-bit press ignored, then a single press for candidate 0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(tbl[i].ballot, tbl[i].btn, tbl[i].clr);
      stepCycle();
      check($sformatf("vec%0d_armed", i), int'(vif.armed), int'(tbl[i].exp_armed));
      check($sformatf("vec%0d_ack", i), int'(vif.vote_ack), int'(tbl[i].exp_ack));
    end
    applyStimulus(1'b0, '0, 1'b0);
    repeat (LC + 2) stepCycle();
    showDigit(0, 1, "tally0_after_table");
    showDigit(1, 0, "tally1_after_table");

    // Held button yields exactly one acknowledge
    applyStimulus(1'b1, '0, 1'b0);
    stepCycle();
    check("arm_latency", int'(vif.armed), 1);
    applyStimulus(1'b0, 4'b0100, 1'b0);
    ack_seen = 0;
    repeat (40) stepCycle();
    check("hold_one_ack", ack_seen, 1);
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) stepCycle();
    showDigit(2, 1, "tally2_held");

    // Eight votes for candidate 1: saturates at 7, eighth sets overflow
    for (int v = 1; v <= 8; v++) begin
      ack_seen = 0;
      castVote(1);
      check($sformatf("sat_ack%0d", v), ack_seen, 1);
      if (v == 7) check("sat_no_ovf_at7", int'(vif.overflow), 0);
    end
    check("sat_overflow", int'(vif.overflow), 4'b0010);
    showDigit(1, 7, "tally1_saturated");

    // clear_all ignored during LOCK
    applyStimulus(1'b1, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'b1000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1);
    repeat (3) stepCycle();
    check("clear_in_lock_ignored", int'(vif.overflow), 4'b0010);
    applyStimulus(1'b0, '0, 1'b0);
    repeat (LC) stepCycle();

    // clear_all wins over ballot_en in IDLE
    applyStimulus(1'b1, '0, 1'b1);
    stepCycle();
    check("clear_overflow", int'(vif.overflow), 0);
    check("clear_no_arm", int'(vif.armed), 0);
    applyStimulus(1'b0, '0, 1'b0);
    stepCycle();
    check("clear_stay_idle", int'(vif.armed), 0);
    showDigit(1, 0, "tally1_cleared");
    showDigit(3, 0, "tally3_cleared");

    // Asynchronous reset during LOCK after a vote for candidate 3
    applyStimulus(1'b1, '0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'b1000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0);
    repeat (2) stepCycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_armed", int'(vif.armed), 0);
    check("arst_ack", int'(vif.vote_ack), 0);
    check("arst_overflow", int'(vif.overflow), 0);
    check("arst_digit_en", int'(vif.digit_en), 1);
    check("arst_seg_count", int'(vif.seg_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    showDigit(3, 0, "tally3_after_reset");
    applyStimulus(1'b1, '0, 1'b0);
    stepCycle();
    check("arst_then_arm", int'(vif.armed), 1);
    applyStimulus(1'b0, '0, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = NC'(1) << $urandom_range(0, NC - 1);
        default: rb = NC'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) == 0, rb, $urandom_range(0, 15) == 0);
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
